// File: rtl/dm_responder_pkg.sv
// rtl/dm_responder_pkg.sv - shared types and constants for the debug-memory responder
`ifndef DM_REGBUS_DEFINED
`define DM_REGBUS_DEFINED
`define RegBus 31:0
`endif

package dm_responder_pkg;

    // Register bus width, matching `RegBus
    localparam int REG_W = 32;

    // Wait counter width: holds WAIT_CYCLES up to 15
    localparam int WAIT_W = 4;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dm_array.sv
// rtl/dm_array.sv - single-port word storage, combinational read, synchronous write, no reset
`ifndef DM_REGBUS_DEFINED
`define DM_REGBUS_DEFINED
`define RegBus 31:0
`endif

module dm_array
    import dm_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [`RegBus]   wdata,
    output logic [`RegBus]   rdata
);

    logic [`RegBus] mem [DEPTH];

    // Storage keeps its contents across reset; only the write enable changes it
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - request/response memory responder with wait states (option: DM_BACK_TO_BACK_EN)
`ifndef DM_REGBUS_DEFINED
`define DM_REGBUS_DEFINED
`define RegBus 31:0
`endif

module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [`RegBus] req_addr,
    input  logic [`RegBus] req_wdata,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [`RegBus] resp_rdata,
    output logic           resp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    // One past the last legal byte address, kept one bit wider so DEPTH*4 never wraps
    localparam logic [REG_W:0] ADDR_LIMIT = (REG_W + 1)'(DEPTH) << 2;

    dm_state_e          state_q;
    logic [WAIT_W-1:0]  cnt_q;
    logic               write_q;
    logic [`RegBus]     addr_q;
    logic [`RegBus]     wdata_q;
    logic               resp_valid_q;
    logic [`RegBus]     resp_rdata_q;
    logic               resp_err_q;

    logic               accept;
    logic               addr_err;
    logic               access_fire;
    logic               arr_we;
    logic [IDX_W-1:0]   arr_idx;
    logic [`RegBus]     arr_rdata;

    // Readiness is a pure decode of state (plus resp_ready when retire and accept may share an edge)
`ifdef DM_BACK_TO_BACK_EN
    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
`else
    assign req_ready = (state_q == IDLE);
`endif

    assign accept      = req_valid && req_ready;
    assign addr_err    = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= ADDR_LIMIT);
    assign access_fire = (state_q == ACCESS) && (cnt_q == '0);
    assign arr_we      = access_fire && write_q && !addr_err;
    assign arr_idx     = addr_q[2 +: IDX_W];

    dm_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Transaction FSM: accept, count wait states, perform access, hold response until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= addr_err;
                        resp_rdata_q <= (!write_q && !addr_err) ? arr_rdata : '0;
                    end else begin
                        cnt_q <= cnt_q - WAIT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // Acceptance overrides the retire-to-IDLE move so back-to-back requests skip IDLE
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt_q   <= WAIT_W'(WAIT_CYCLES);
                state_q <= ACCESS;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed table-driven bench for dm_responder
module tb_dm_responder;

    localparam int DEPTH = 1024;
    localparam int WAIT  = 2;
    localparam int LAT   = 1 + WAIT;
`ifdef DM_BACK_TO_BACK_EN
    localparam int GAP   = 1 + WAIT;
`else
    localparam int GAP   = 2 + WAIT;
`endif

    logic        clk;
    logic        rst;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        v0, rdy0, w0, rv0, rr0, er0;
    logic [31:0] a0, d0, rd0;

    int n_cmp = 0;
    int n_bad = 0;

    dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    dm_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (v0),
        .req_ready  (rdy0),
        .req_write  (w0),
        .req_addr   (a0),
        .req_wdata  (d0),
        .resp_valid (rv0),
        .resp_ready (rr0),
        .resp_rdata (rd0),
        .resp_err   (er0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns when resp_valid is seen (or the bound expires)
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic rr, output logic [31:0] rd, output logic er, output int lat);
        int guard;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = rr;
        req_valid  = 1'b1;
        guard = 0;
        while (!req_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    task automatic retire(input string nm);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_retired"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n_acc;
        int          npulse;
        int          t_pulse[4];
        logic        will_acc;

        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0,   32'h12345678, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h20,  32'hAAAA5555, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h12,  32'h0,        32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 32'h0, 1'b1};
        vecs[6]  = '{1'b1, 32'h1,   32'h00000055, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0};
        vecs[8]  = '{1'b1, 32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'hFFC, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b0, 32'h20,  32'h0,        32'hAAAA5555, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0; rr0 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err",   32'(resp_err), 32'd0);
        chk("rst_req_ready",  32'(req_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven transactions
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b1, rd, er, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_retired", i), 32'(resp_valid), 32'd0);
        end

        // Response held with resp_ready low for 5 cycles
        send(1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
        chk("hold_latency", 32'(lat), 32'(LAT));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_valid", c), 32'(resp_valid), 32'd1);
            chk($sformatf("hold%0d_rdata", c), resp_rdata, 32'hDEADBEEF);
            chk($sformatf("hold%0d_req_ready", c), 32'(req_ready), 32'd0);
        end
        retire("hold");
        chk("hold_idle_ready", 32'(req_ready), 32'd1);

        // Four reads with req_valid held and resp_ready tied high
        req_write = 1'b0; req_addr = 32'h10; req_wdata = '0; resp_ready = 1'b1;
        req_valid = 1'b1;
        n_acc = 0;
        npulse = 0;
        for (int cyc = 0; cyc < 80 && npulse < 4; cyc++) begin
            will_acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (will_acc) begin
                n_acc++;
                if (n_acc == 4) req_valid = 1'b0;
            end
            if (resp_valid) begin
                t_pulse[npulse] = cyc;
                chk($sformatf("b2b%0d_rdata", npulse), resp_rdata, 32'hDEADBEEF);
                npulse++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_pulses", 32'(npulse), 32'd4);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("b2b_gap%0d", i), 32'(t_pulse[i] - t_pulse[i-1] - 1), 32'(GAP));
        end
        @(posedge clk); #1;
        chk("b2b_drained", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;

        // Reset during the ACCESS phase of a write to 0x20
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BADF00D; resp_ready = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_resp_rdata", resp_rdata, 32'd0);
        chk("midrst_resp_err",   32'(resp_err), 32'd0);
        chk("midrst_req_ready",  32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(1'b0, 32'h20, 32'h0, 1'b1, rd, er, lat);
        chk("midrst_readback", rd, 32'hAAAA5555);
        chk("midrst_readback_err", 32'(er), 32'd0);
        retire("midrst");

        // Zero wait-state instance: write then read word 0
        w0 = 1'b1; a0 = 32'h0; d0 = 32'h0000ABCD; rr0 = 1'b1; v0 = 1'b1;
        chk("w0_ready", 32'(rdy0), 32'd1);
        @(posedge clk); #1;
        v0 = 1'b0;
        @(posedge clk); #1;
        chk("w0_wr_latency1", 32'(rv0), 32'd1);
        chk("w0_wr_err", 32'(er0), 32'd0);
        @(posedge clk); #1;
        w0 = 1'b0; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        chk("w0_rd_not_yet", 32'(rv0), 32'd0);
        @(posedge clk); #1;
        chk("w0_rd_latency1", 32'(rv0), 32'd1);
        chk("w0_rd_rdata", rd0, 32'h0000ABCD);
        chk("w0_rd_err", 32'(er0), 32'd0);
        @(posedge clk); #1;
        chk("w0_retired", 32'(rv0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
